upht_update_wb: RTL and testbench

- Update-side consumer of the saturating-counter FIFO that sits between the micro-PHT read port and branch resolution.
- On each resolved branch it pops the counter value captured at predict time and computes the next 2-bit saturating value from the actual direction.
- It queues the result in a small write buffer and drains that buffer into the uPHT write port under a grant handshake. Predictor reads keep priority on the PHT.

---
 rtl/upht_update_wb.sv | 117 +++++++++++
 tb/tb_upht_update_wb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/upht_update_wb.sv
// Update-side write buffer for the micro-PHT: pops predict-time counters, computes the
// saturating update, and drains queued writes under grant. Optional macro: UPHT_WB_FWD_EN.
module upht_update_wb #(
    parameter int IDX_WIDTH = 6,
    parameter int CNT_WIDTH = 2,
    parameter int WB_DEPTH  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_resolve_vld,
    input  logic                 i_resolve_taken,
    input  logic [IDX_WIDTH-1:0] i_resolve_idx,
    output logic                 o_resolve_rdy,
    input  logic [CNT_WIDTH-1:0] i_fifo_cnt,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_pop,
    output logic                 o_pht_wr_en,
    output logic [IDX_WIDTH-1:0] o_pht_wr_idx,
    output logic [CNT_WIDTH-1:0] o_pht_wr_cnt,
    input  logic                 i_pht_wr_gnt,
    output logic                 o_underflow,
    output logic                 o_wb_empty
);
    localparam int PTR_W   = $clog2(WB_DEPTH);
    localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

    logic [PTR_W-1:0]     head_reg, tail_reg;
    logic [PTR_W:0]       count_reg, count_next;
    logic                 underflow_reg;
    logic [IDX_WIDTH-1:0] idx_mem [WB_DEPTH];
    logic [CNT_WIDTH-1:0] cnt_mem [WB_DEPTH];

    logic                 accept, enq, retire;
    logic [CNT_WIDTH-1:0] base_cnt, next_cnt;
    logic [CNT_WIDTH:0]   base_ext, inc_ext, dec_ext;

    assign o_resolve_rdy = count_reg < (PTR_W+1)'(WB_DEPTH);
    assign accept        = i_resolve_vld && o_resolve_rdy;
    assign o_fifo_pop    = accept && !i_fifo_empty;

`ifdef UPHT_WB_FWD_EN
    logic [WB_DEPTH-1:0] match_w;
    logic [PTR_W-1:0]    slot;

    // A slot is live when its age behind the head is below the occupancy.
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_match
        logic [PTR_W-1:0] age;
        assign age = PTR_W'(gi) - head_reg;
        assign match_w[gi] = ({1'b0, age} < count_reg) && (idx_mem[gi] == i_resolve_idx);
    end

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        base_cnt = i_fifo_cnt;
        slot     = head_reg;
        for (int k = 0; k < WB_DEPTH; k++) begin
            slot = head_reg + PTR_W'(k);
            if (match_w[slot]) base_cnt = cnt_mem[slot];
        end
    end
`else
    assign base_cnt = i_fifo_cnt;
`endif

    // Saturating step computed one bit wider, then clamped back into range.
    assign base_ext = {1'b0, base_cnt};
    assign inc_ext  = base_ext + (CNT_WIDTH+1)'(1);
    assign dec_ext  = base_ext - (CNT_WIDTH+1)'(1);

    always_comb begin
        next_cnt = base_cnt;
        if (i_resolve_taken) begin
            if (inc_ext > (CNT_WIDTH+1)'(CNT_MAX)) next_cnt = CNT_WIDTH'(CNT_MAX);
            else                                   next_cnt = inc_ext[CNT_WIDTH-1:0];
        end else begin
            if (dec_ext[CNT_WIDTH]) next_cnt = '0;
            else                    next_cnt = dec_ext[CNT_WIDTH-1:0];
        end
    end

    assign enq    = o_fifo_pop && (next_cnt != base_cnt);
    assign retire = o_pht_wr_en && i_pht_wr_gnt;

    always_comb begin
        count_next = count_reg;
        if (enq && !retire)      count_next = count_reg + (PTR_W+1)'(1);
        else if (!enq && retire) count_next = count_reg - (PTR_W+1)'(1);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            if (enq)    tail_reg <= tail_reg + PTR_W'(1);
            if (retire) head_reg <= head_reg + PTR_W'(1);
            count_reg <= count_next;
            if (accept && i_fifo_empty) underflow_reg <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            idx_mem[tail_reg] <= i_resolve_idx;
            cnt_mem[tail_reg] <= next_cnt;
        end
    end

    assign o_pht_wr_en  = (count_reg != '0);
    assign o_wb_empty   = (count_reg == '0);
    assign o_pht_wr_idx = o_pht_wr_en ? idx_mem[head_reg] : '0;
    assign o_pht_wr_cnt = o_pht_wr_en ? cnt_mem[head_reg] : '0;
    assign o_underflow  = underflow_reg;
endmodule

// File: tb/tb_upht_update_wb.sv
// Randomized and directed bench for upht_update_wb against a queue-based reference model.
module tb_upht_update_wb;
    localparam int D = 4;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_resolve_vld = 1'b0, i_resolve_taken = 1'b0;
    logic [5:0] i_resolve_idx = '0;
    logic       o_resolve_rdy;
    logic [1:0] i_fifo_cnt = '0;
    logic       i_fifo_empty = 1'b0;
    logic       o_fifo_pop, o_pht_wr_en;
    logic [5:0] o_pht_wr_idx;
    logic [1:0] o_pht_wr_cnt;
    logic       i_pht_wr_gnt = 1'b0;
    logic       o_underflow, o_wb_empty;

    upht_update_wb #(.IDX_WIDTH(6), .CNT_WIDTH(2), .WB_DEPTH(D)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_resolve_vld(i_resolve_vld), .i_resolve_taken(i_resolve_taken),
        .i_resolve_idx(i_resolve_idx), .o_resolve_rdy(o_resolve_rdy),
        .i_fifo_cnt(i_fifo_cnt), .i_fifo_empty(i_fifo_empty), .o_fifo_pop(o_fifo_pop),
        .o_pht_wr_en(o_pht_wr_en), .o_pht_wr_idx(o_pht_wr_idx), .o_pht_wr_cnt(o_pht_wr_cnt),
        .i_pht_wr_gnt(i_pht_wr_gnt), .o_underflow(o_underflow), .o_wb_empty(o_wb_empty)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int idx;
        int cnt;
    } ent_t;

    ent_t q[$];
    bit   uf_model = 0;
    int   checks = 0, failures = 0, writes_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input bit vld, input bit taken, input int idx, input int fc,
                        input bit fe, input bit gnt);
        bit accept, exp_pop;
        int base, nx;
        ent_t e;
        i_resolve_vld = vld; i_resolve_taken = taken; i_resolve_idx = 6'(idx);
        i_fifo_cnt = 2'(fc); i_fifo_empty = fe; i_pht_wr_gnt = gnt;
        #1;
        accept = vld && (q.size() < D);
        base = fc;
`ifdef UPHT_WB_FWD_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].idx == idx) begin
                base = q[i].cnt;
                break;
            end
        end
`endif
        nx = taken ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
        exp_pop = accept && !fe;
        check("rdy", 32'(o_resolve_rdy), 32'(q.size() < D));
        check("pop", 32'(o_fifo_pop), 32'(exp_pop));
        check("wr_en", 32'(o_pht_wr_en), 32'(q.size() != 0));
        check("wr_idx", 32'(o_pht_wr_idx), (q.size() != 0) ? 32'(q[0].idx) : 32'd0);
        check("wr_cnt", 32'(o_pht_wr_cnt), (q.size() != 0) ? 32'(q[0].cnt) : 32'd0);
        check("underflow", 32'(o_underflow), 32'(uf_model));
        check("wb_empty", 32'(o_wb_empty), 32'(q.size() == 0));
        @(posedge i_clk);
        if (q.size() != 0 && gnt) begin
            void'(q.pop_front());
            writes_seen++;
        end
        if (accept)
            $display("resolve idx=%0d taken=%0d fifo_empty=%0d base=%0d next=%0d queued=%0d",
                     idx, taken, fe, base, nx, exp_pop && (nx != base));
        if (exp_pop && nx != base) begin
            e.idx = idx; e.cnt = nx;
            q.push_back(e);
        end
        if (accept && fe) uf_model = 1;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0; i_resolve_vld = 1'b0; i_pht_wr_gnt = 1'b0; i_fifo_empty = 1'b0;
        #1;
        q.delete(); uf_model = 0;
        check("rst_wr_en", 32'(o_pht_wr_en), 32'd0);
        check("rst_pop", 32'(o_fifo_pop), 32'd0);
        check("rst_underflow", 32'(o_underflow), 32'd0);
        check("rst_wb_empty", 32'(o_wb_empty), 32'd1);
        check("rst_rdy", 32'(o_resolve_rdy), 32'd1);
        check("rst_wr_idx", 32'(o_pht_wr_idx), 32'd0);
        check("rst_wr_cnt", 32'(o_pht_wr_cnt), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    initial begin
        @(negedge i_clk);
        do_reset();

        // Basic update: pop in N, write in N+1, empty in N+2.
        step(1, 1, 5, 1, 0, 1);
        check("first_wr_en", 32'(o_pht_wr_en), 32'd1);
        check("first_wr_cnt", 32'(o_pht_wr_cnt), 32'd2);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Already saturated in both directions: pop but no write.
        step(1, 0, 9, 0, 0, 1);
        step(1, 1, 9, 3, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Fill with no grant, fifth is refused, then drain in order.
        for (int i = 0; i < 5; i++) step(1, 1, 10 + i, i % 3, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

        // Underflow is sticky through later traffic until reset.
        step(1, 1, 3, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, i[0], 20 + i, 1, 0, 1);
        do_reset();

        // Held valid against a full buffer: one accept per retire, pointers wrap.
        for (int i = 0; i < D; i++) step(1, 1, 30 + i, 0, 0, 0);
        for (int i = 0; i < 3 * D + 4; i++) step(1, 1, 40 + i, 0, 0, 1);
        for (int i = 0; i < D + 1; i++) step(0, 0, 0, 0, 0, 1);
        check("wrap_writes", 32'(writes_seen >= 3 * D), 32'd1);

        // Same-index back-to-back; model applies forwarding only when the macro is set.
        step(1, 1, 7, 1, 0, 0);
        step(1, 1, 7, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
`ifdef UPHT_WB_FWD_EN
        check("fwd_second_cnt", 32'(o_pht_wr_cnt), 32'd3);
`else
        check("fwd_second_cnt", 32'(o_pht_wr_cnt), 32'd2);
`endif
        step(0, 0, 0, 0, 0, 1);

        // Reset in the middle of a drain discards everything.
        for (int i = 0; i < 3; i++) step(1, 0, 50 + i, 3, 0, 0);
        do_reset();

        // Randomized traffic with small index range to provoke same-index hazards.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
